logic_unit_scheduler: RTL and testbench

Round-robin scheduler that time-shares one configurable 1–4-input logic evaluation unit (AND/OR/XOR/NAND/NOR, matching the gate-cell set) among `N_REQ` requesters. Each cycle it grants at most one pending request, configures the shared unit's op and arity, and carries the result through a `LATENCY`-stage pipeline that models gate tick delay. It then returns the result to the originating requester. It sits between client logic and the single shared gate resource.

---
 rtl/logic_unit_pkg.sv | 54 +++++
 rtl/logic_unit_scheduler_rr_arbiter.sv | 49 ++++
 rtl/logic_unit_scheduler.sv | 104 ++++++++++
 tb/tb_logic_unit_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and the evaluation function for the time-shared logic unit.
package logic_unit_pkg;

    localparam int OP_W    = 3;
    localparam int ARITY_W = 2;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4
    } op_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            data;
        logic            err;
    } stage_t;

    // Returns {result, err}. Operand bits above the arity are replaced by the
    // op's identity so the reduction over all four bits only sees live inputs.
    function automatic logic [1:0] eval_op(
        input logic [OP_W-1:0]    op,
        input logic [ARITY_W-1:0] arity,
        input logic [DATA_W-1:0]  data
    );
        logic [DATA_W-1:0] masked;
        logic              ident;
        logic              res;
        logic              err;
        ident = (op == OP_AND) || (op == OP_NAND);
        for (int b = 0; b < DATA_W; b++) begin
            masked[b] = (b > int'(arity)) ? ident : data[b];
        end
        err = 1'b0;
        case (op)
            OP_AND:  res = &masked;
            OP_OR:   res = |masked;
            OP_XOR:  res = ^masked;
            OP_NAND: res = ~&masked;
            OP_NOR:  res = ~|masked;
            default: begin
                res = 1'b0;
                err = 1'b1;
            end
        endcase
        return {res, err};
    endfunction

endpackage

// File: rtl/logic_unit_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] ptr
);

    logic [2*N-1:0] rot;

    assign rot = {req, req} >> ptr;

    // Pick the first pending request in rotated order starting at ptr.
    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                j     = int'(ptr) + k;
                if (j >= N) j = j - N;
                idx   = IDX_W'(j);
            end
        end
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (idx == IDX_W'(i));
        end
    end

    // Move the pointer just past the requester that was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Time-shares one 1..4-input logic unit among N_REQ requesters, with a
// fixed-latency result pipeline and per-requester response demux.
module logic_unit_scheduler
    import logic_unit_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [3*N_REQ-1:0]   req_op,
    input  logic [2*N_REQ-1:0]   req_arity,
    input  logic [4*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [N_REQ-1:0]     rsp_data,
    output logic [N_REQ-1:0]     rsp_err,
    output logic                 busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   rr_ptr_unused;
    logic               accept;
    logic [OP_W-1:0]    sel_op;
    logic [ARITY_W-1:0] sel_arity;
    logic [DATA_W-1:0]  sel_data;
    logic [1:0]         ev;
    stage_t             pipe [LATENCY];

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .ptr     (rr_ptr_unused)
    );

    // Nothing is accepted while reset is held.
    assign req_ready = rst ? '0 : arb_grant;
    assign accept    = |(req_valid & req_ready);

    // Route the granted requester's fields to the shared unit.
    always_comb begin
        sel_op    = '0;
        sel_arity = '0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                sel_op    = req_op[3*i +: 3];
                sel_arity = req_arity[2*i +: 2];
                sel_data  = req_data[4*i +: 4];
            end
        end
    end

    assign ev = eval_op(sel_op, sel_arity, sel_data);

    // Result pipeline modelling gate delay; shifts every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0].valid <= accept;
            pipe[0].id    <= ID_W'(arb_idx);
            pipe[0].data  <= ev[1];
            pipe[0].err   <= ev[0];
            for (int s = 1; s < LATENCY; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    // Demux the final stage to its requester; an entry sitting in the last
    // stage during a reset cycle is dropped along with the rest.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pipe[LATENCY-1].valid && !rst && (pipe[LATENCY-1].id == ID_W'(i))) begin
                rsp_valid[i] = 1'b1;
                rsp_data[i]  = pipe[LATENCY-1].data;
                rsp_err[i]   = pipe[LATENCY-1].err;
            end
        end
    end

    // Busy while any stage holds a live entry.
    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            busy = busy | pipe[s].valid;
        end
    end

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed bench for logic_unit_scheduler (N_REQ=4, LATENCY=2).
module tb_logic_unit_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [7:0]  req_arity;
    logic [15:0] req_data;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_data;
    logic [3:0]  rsp_err;
    logic        busy;

    int vectors;
    int miscompares;

    logic_unit_scheduler #(.N_REQ(4), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_arity (req_arity),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [1:0] ar, input logic [3:0] d);
        req_op[3*i +: 3]    = op;
        req_arity[2*i +: 2] = ar;
        req_data[4*i +: 4]  = d;
    endtask

    // One isolated request: ready, pipeline occupancy, response cycle, idle after.
    task automatic do_single(input string tag, input int i, input logic [2:0] op,
                             input logic [1:0] ar, input logic [3:0] d,
                             input logic exp_d, input logic exp_e);
        logic [3:0] onehot;
        onehot = 4'b0001 << i;
        set_req(i, op, ar, d);
        req_valid = onehot;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(onehot));
        tick();
        req_valid = 4'b0000;
        #1;
        check({tag, "_busy_inflight"}, 32'(busy), 32'd1);
        check({tag, "_no_early_rsp"}, 32'(rsp_valid), 32'd0);
        tick();
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(onehot));
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_d ? onehot : 4'b0000));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_e ? onehot : 4'b0000));
        tick();
        check({tag, "_rsp_gone"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] rr_res;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_arity = '0;
        req_data  = '0;
        tick();
        tick();

        // Requests during reset are refused
        req_valid = 4'hF;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        rst = 1'b0;

        // Reset then idle
        repeat (10) tick();
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_rsp_data", 32'(rsp_data), 32'd0);
        check("idle_rsp_err", 32'(rsp_err), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_ptr", 32'(dut.u_arb.ptr), 32'd0);

        // Single request and arity masking (ptr walks 0->3->1->0->3->2->2->2)
        do_single("xor_r2", 2, 3'd2, 2'd2, 4'b0111, 1'b1, 1'b0);
        do_single("nand_r0", 0, 3'd3, 2'd1, 4'b0011, 1'b0, 1'b0);
        do_single("nor_not_r3", 3, 3'd4, 2'd0, 4'b1110, 1'b1, 1'b0);
        do_single("and_pass_r2", 2, 3'd0, 2'd0, 4'b1110, 1'b0, 1'b0);
        do_single("or4_r1", 1, 3'd1, 2'd3, 4'b1000, 1'b1, 1'b0);
        do_single("illegal_r1", 1, 3'd6, 2'd0, 4'b1111, 1'b0, 1'b1);
        do_single("after_illegal_r1", 1, 3'd2, 2'd3, 4'b1011, 1'b1, 1'b0);
        check("ptr_after_singles", 32'(dut.u_arb.ptr), 32'd2);

        // Reset pulse to bring ptr back to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("ptr_after_reset", 32'(dut.u_arb.ptr), 32'd0);

        // Round-robin: all valid for 8 cycles
        set_req(0, 3'd0, 2'd3, 4'b1111);   // AND  -> 1
        set_req(1, 3'd1, 2'd0, 4'b0000);   // OR   -> 0
        set_req(2, 3'd2, 2'd1, 4'b0011);   // XOR  -> 0
        set_req(3, 3'd4, 2'd1, 4'b0000);   // NOR  -> 1
        rr_res = 4'b1001;
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            logic [3:0] g;
            logic [3:0] r;
            if (c == 8) req_valid = 4'h0;
            #1;
            g = 4'b0001 << (c % 4);
            r = 4'b0001 << ((c + 2) % 4);
            check($sformatf("rr_grant_%0d", c), 32'(req_ready), (c < 8) ? 32'(g) : 32'd0);
            check($sformatf("rr_rsp_valid_%0d", c), 32'(rsp_valid), (c >= 2) ? 32'(r) : 32'd0);
            if (c >= 2) begin
                check($sformatf("rr_rsp_data_%0d", c), 32'(rsp_data), 32'(r & rr_res));
                check($sformatf("rr_rsp_err_%0d", c), 32'(rsp_err), 32'd0);
            end
            tick();
        end
        check("rr_idle", 32'(busy), 32'd0);

        // Reset mid-flight
        req_valid = 4'b0011;
        #1;
        check("mid_grant0", 32'(req_ready), 32'b0001);
        tick();
        #1;
        check("mid_grant1", 32'(req_ready), 32'b0010);
        tick();
        rst = 1'b1;
        #1;
        check("mid_ready_in_reset", 32'(req_ready), 32'd0);
        check("mid_rsp_in_reset", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;
        #1;
        check("mid_ptr", 32'(dut.u_arb.ptr), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("mid_no_rsp_%0d", c), 32'(rsp_valid), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
